// File: rtl/fp_row_sum_organizer.sv
// FP32 row reduction: binary adder tree over one package per clock plus a burst accumulator.
// Define ORG_PIPELINE_EN to register every tree level; otherwise the tree is one combinational stage.
module fp_row_sum_organizer #(
   parameter int no_of_units   = 8,
   parameter int element_width = 32
) (
   input  logic                                   clk,
   input  logic                                   main_reset,
   input  logic [element_width*no_of_units-1:0]   package_in,
   input  logic                                   start,
   input  logic                                   read_now,
   output logic [element_width-1:0]               adder_output,
   output logic                                   final_finish,
   output logic                                   tree_finish
);

   localparam int ew     = element_width;
   localparam int levels = $clog2(no_of_units);
`ifdef ORG_PIPELINE_EN
   localparam bit pipe_en = 1'b1;
`else
   localparam bit pipe_en = 1'b0;
`endif

   // FP32 add, round-to-nearest-even; denormals in and out become +0, exact zero is +0.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]       x, y, res;
      logic [26:0]       mx, my, ms;
      logic [27:0]       sum;
      logic [7:0]        d;
      logic [4:0]        lz;
      logic signed [9:0] e;
      logic [24:0]       rm;
      logic              rnd;
      res = 32'h0000_0000;
      if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
         res = 32'h0000_0000;
      end else if (a[30:23] == 8'd0) begin
         res = b;
      end else if (b[30:23] == 8'd0) begin
         res = a;
      end else begin
         if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
         end else begin
            x = b;
            y = a;
         end
         mx = {1'b1, x[22:0], 3'b000};
         my = {1'b1, y[22:0], 3'b000};
         d  = x[30:23] - y[30:23];
         if (d >= 8'd27) begin
            my = 27'd1;
         end else begin
            my = (my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))};
         end
         e = $signed({2'b00, x[30:23]});
         if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[27]) begin
               ms = {sum[27:2], sum[1] | sum[0]};
               e  = e + 10'sd1;
            end else begin
               ms = sum[26:0];
            end
         end else begin
            ms = mx - my;
            lz = 5'd0;
            for (int i = 0; i < 27; i++) begin
               if (ms[i]) lz = 5'(26 - i);
            end
            ms = ms << lz;
            e  = e - $signed({5'd0, lz});
         end
         rnd = ms[2] & (ms[1] | ms[0] | ms[3]);
         rm  = {1'b0, ms[26:3]} + {24'd0, rnd};
         if (rm[24]) begin
            rm = rm >> 1'b1;
            e  = e + 10'sd1;
         end else begin
            rm = rm;
         end
         if (ms == 27'd0 || e <= 10'sd0) begin
            res = 32'h0000_0000;
         end else if (e >= 10'sd255) begin
            res = {x[31], 8'hFF, 23'd0};
         end else begin
            res = {x[31], e[7:0], rm[22:0]};
         end
      end
      return res;
   endfunction

   logic [ew*no_of_units-1:0] in_r;
   logic                      in_vld_r, in_fst_r, prev_read_r;

   // Input register; a burst starts whenever read_now was low on the previous edge.
   always_ff @(posedge clk) begin
      if (main_reset) begin
         in_r        <= {(ew*no_of_units){1'b0}};
         in_vld_r    <= 1'b0;
         in_fst_r    <= 1'b0;
         prev_read_r <= 1'b0;
      end else begin
         prev_read_r <= read_now;
         in_vld_r    <= start & read_now;
         if (start & read_now) begin
            in_r     <= package_in;
            in_fst_r <= ~prev_read_r;
         end else begin
            in_r     <= in_r;
            in_fst_r <= in_fst_r;
         end
      end
   end

   for (genvar k = 1; k <= levels; k++) begin : lvl
      localparam int w = no_of_units >> k;
      logic [2*w*ew-1:0] src;
      logic [w*ew-1:0]   sum_s, v;
      logic              src_vld, src_fst, vld, fst;

      if (k == 1) begin : g_src
         assign src     = in_r;
         assign src_vld = in_vld_r;
         assign src_fst = in_fst_r;
      end else begin : g_src
         assign src     = lvl[k-1].v;
         assign src_vld = lvl[k-1].vld;
         assign src_fst = lvl[k-1].fst;
      end

      // Pairwise sums of the previous level.
      always_comb begin
         sum_s = {(w*ew){1'b0}};
         for (int i = 0; i < w; i++) begin
            sum_s[i*ew +: ew] = fp_add(src[(2*i+1)*ew +: ew], src[2*i*ew +: ew]);
         end
      end

      // The last level is always registered so tree_finish is a clean strobe.
      if (pipe_en || k == levels) begin : g_reg
         // Level register carrying data with its valid and burst-start flags.
         always_ff @(posedge clk) begin
            if (main_reset) begin
               v   <= {(w*ew){1'b0}};
               vld <= 1'b0;
               fst <= 1'b0;
            end else begin
               v   <= sum_s;
               vld <= src_vld;
               fst <= src_fst;
            end
         end
      end else begin : g_comb
         assign v   = sum_s;
         assign vld = src_vld;
         assign fst = src_fst;
      end
   end

   logic [ew-1:0] tree_sum_s;
   assign tree_sum_s  = lvl[levels].v;
   assign tree_finish = lvl[levels].vld;

   // Burst accumulator: restart on the first package of a burst, otherwise add.
   always_ff @(posedge clk) begin
      if (main_reset) begin
         adder_output <= {ew{1'b0}};
         final_finish <= 1'b0;
      end else if (tree_finish) begin
         adder_output <= lvl[levels].fst ? tree_sum_s : fp_add(adder_output, tree_sum_s);
         final_finish <= 1'b1;
      end else begin
         adder_output <= adder_output;
         final_finish <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_row_sum_organizer.sv
// Directed bench for fp_row_sum_organizer (N=8); latency follows ORG_PIPELINE_EN.
module tb_fp_row_sum_organizer;
   localparam int n = 8;
`ifdef ORG_PIPELINE_EN
   localparam int tree_lat = 3;
`else
   localparam int tree_lat = 1;
`endif
   localparam logic [31:0] one  = 32'h3F80_0000;
   localparam logic [31:0] mone = 32'hBF80_0000;
   localparam logic [31:0] two  = 32'h4000_0000;
   localparam logic [31:0] thr  = 32'h4040_0000;
   localparam logic [31:0] zro  = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          main_reset = 1'b1;
   logic [n*32-1:0] package_in = {(n*32){1'b0}};
   logic          start = 1'b0;
   logic          read_now = 1'b0;
   logic [31:0]   adder_output;
   logic          final_finish, tree_finish;
   int            vectors = 0;
   int            miscompares = 0;

   fp_row_sum_organizer #(.no_of_units(n), .element_width(32)) dut (
      .clk(clk), .main_reset(main_reset), .package_in(package_in), .start(start),
      .read_now(read_now), .adder_output(adder_output), .final_finish(final_finish),
      .tree_finish(tree_finish));

   always #5 clk = ~clk;

   function automatic logic [n*32-1:0] mk(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
      return {e0, e1, e2, e3, e4, e5, e6, e7};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One isolated package: checks tree strobe timing, result and strobe width.
   task automatic run_single(input string tag, input logic [n*32-1:0] pkg, input logic [31:0] exp);
      start = 1'b1; read_now = 1'b1; package_in = pkg;
      tick();
      read_now = 1'b0;
      for (int c = 1; c < tree_lat; c++) begin
         tick();
         check({tag, "_tf_early"}, {31'd0, tree_finish}, 32'd0);
      end
      tick();
      check({tag, "_tf"}, {31'd0, tree_finish}, 32'd1);
      check({tag, "_ff_early"}, {31'd0, final_finish}, 32'd0);
      tick();
      check({tag, "_ff"}, {31'd0, final_finish}, 32'd1);
      check({tag, "_sum"}, adder_output, exp);
      tick();
      check({tag, "_ff_end"}, {31'd0, final_finish}, 32'd0);
      check({tag, "_hold"}, adder_output, exp);
   endtask

   initial begin
      tick(); tick();
      check("rst_out", adder_output, 32'd0);
      check("rst_ff", {31'd0, final_finish}, 32'd0);
      check("rst_tf", {31'd0, tree_finish}, 32'd0);
      main_reset = 1'b0;
      tick();

      run_single("ones", mk(one, one, one, one, one, one, one, one), 32'h4100_0000);

      // Two-package burst: strobes back to back, second result accumulates.
      start = 1'b1; read_now = 1'b1;
      package_in = mk(one, one, one, one, one, one, one, one);
      tick();
      package_in = mk(two, two, two, two, two, two, two, two);
      tick();
      read_now = 1'b0;
      for (int c = 2; c < tree_lat; c++) tick();
      if (tree_lat == 1) begin
         check("burst_tf1", {31'd0, tree_finish}, 32'd1);
      end else begin
         tick();
         check("burst_tf1", {31'd0, tree_finish}, 32'd1);
      end
      tick();
      check("burst_tf2", {31'd0, tree_finish}, 32'd1);
      check("burst_ff1", {31'd0, final_finish}, 32'd1);
      check("burst_sum1", adder_output, 32'h4100_0000);
      tick();
      check("burst_ff2", {31'd0, final_finish}, 32'd1);
      check("burst_sum2", adder_output, 32'h41C0_0000);
      tick();
      check("burst_ff_end", {31'd0, final_finish}, 32'd0);

      run_single("restart", mk(thr, thr, thr, thr, thr, thr, thr, thr), 32'h41C0_0000);
      run_single("cancel", mk(one, mone, one, mone, one, mone, one, mone), zro);
      run_single("mixed", mk(32'h3FC0_0000, 32'h4010_0000, zro, zro, zro, zro, zro, 32'hBF40_0000),
                 32'h4040_0000);
      run_single("denorm", mk(32'h0040_0000, 32'h8000_0000, zro, zro, zro, zro, zro, zro), zro);
      run_single("rne_tie_even", mk(32'h4B80_0000, one, zro, zro, zro, zro, zro, zro), 32'h4B80_0000);
      run_single("rne_tie_up", mk(32'h4B80_0000, thr, zro, zro, zro, zro, zro, zro), 32'h4B80_0002);

      // read_now without start: nothing sampled.
      start = 1'b0; read_now = 1'b1;
      package_in = mk(two, two, two, two, two, two, two, two);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("nostart_tf", {31'd0, tree_finish}, 32'd0);
         check("nostart_ff", {31'd0, final_finish}, 32'd0);
      end
      check("nostart_hold", adder_output, 32'h4B80_0002);
      read_now = 1'b0;
      tick();

      // Reset with two packages in flight discards them.
      start = 1'b1; read_now = 1'b1;
      package_in = mk(one, one, one, one, one, one, one, one);
      tick(); tick();
      main_reset = 1'b1; read_now = 1'b0;
      tick();
      check("flush_out", adder_output, 32'd0);
      check("flush_ff", {31'd0, final_finish}, 32'd0);
      check("flush_tf", {31'd0, tree_finish}, 32'd0);
      main_reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         check("flush_quiet_tf", {31'd0, tree_finish}, 32'd0);
         check("flush_quiet_ff", {31'd0, final_finish}, 32'd0);
      end
      check("flush_quiet_out", adder_output, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fp_row_sum_organizer.md
Name: fp_row_sum_organizer

Overview:
- Floating-point reduction stage of the dot-product row engine.
- Takes a packed vector of no_of_units IEEE-754 single-precision products per valid cycle and sums it through a binary adder tree.
- Accumulates successive tree sums belonging to one burst (row segment) into a running total.
- Emits per-package and per-accumulation strobes that the row controller counts to detect row completion.

Parameters:
- no_of_units, 8, number of FP32 elements per package; power of two, at least 2.
- element_width, 32, element width in bits; fixed at 32 (FP32).

Ports:
- clk  input  1  single clock, rising edge.
- main_reset  input  1  synchronous, active-high reset.
- package_in  input  element_width*no_of_units  packed elements; element 0 occupies the MSBs.
- start  input  1  enable; a package is sampled only while high.
- read_now  input  1  package-valid qualifier for the current cycle.
- adder_output  output  element_width  running FP32 accumulation of the current burst.
- final_finish  output  1  one-cycle strobe: adder_output has just been updated.
- tree_finish  output  1  one-cycle strobe: a tree sum has just completed.

Behaviour:
- Reset: main_reset=1 at an edge clears all pipeline registers, valid and first flags, the accumulator, adder_output, final_finish and tree_finish to 0. Reset overrides all other activity, including in-flight packages, which are discarded.
- Sampling: at edge t, if start=1 and read_now=1, package_in is captured into the input register with valid=1.
- First flag: the first flag is set when read_now was 0 on the previous edge or this is the first sample after reset. It marks the start of a burst and travels with the data.
- start=0: nothing is sampled. Packages already in flight still complete normally.
- Tree: log2(no_of_units) levels. Level k adds adjacent pairs from level k-1 (element 2i with element 2i+1).
- Tree latency with ORG_PIPELINE_EN: each level is registered. The tree sum and tree_finish=1 are registered at edge t+log2(no_of_units); for N=8 this is edge t+3.
- Accumulator: at the edge after tree_finish, the accumulator loads the tree sum if the first flag is set, otherwise it loads accumulator + tree sum. adder_output follows the accumulator, and final_finish=1 for that one cycle.
- Strobe rate: strobes are one cycle per package. Back-to-back packages produce back-to-back strobes, giving a sustained throughput of one package per clock.
- Arithmetic: combinational FP32 add, round-to-nearest-even. Denormal inputs and results are flushed to +0. An exact zero result is +0 (0x00000000). Inf/NaN handling is not required.
- Idle: when no package completes, both strobes are 0 and adder_output holds its value.

Optional Feature:
- Macro ORG_PIPELINE_EN.
- Defined: one register per tree level. Tree latency is log2(no_of_units) edges; accumulator latency is one more edge.
- Undefined: the whole tree is combinational from the input register. The tree sum and tree_finish are registered at edge t+1, and the accumulator and final_finish at edge t+2.
- Accumulation semantics are identical in both builds.

Test Plan:
- N=8, one package of all 1.0 (0x3F800000) with start=1, read_now pulsed once -> tree_finish after 3 edges (pipelined build); final_finish one edge later with adder_output=0x41000000 (8.0).
- Burst of two consecutive packages, all 1.0 then all 2.0 -> two final_finish strobes on consecutive cycles; adder_output 0x41000000, then 0x41C00000 (24.0).
- Two bursts separated by a read_now=0 gap -> the second burst's first result restarts the accumulator: all 3.0 gives 0x41C00000, with no carry-over from the previous burst.
- Alternating +1.0/−1.0 package -> adder_output=0x00000000. Mixed values 1.5, 2.25, 0, 0, 0, 0, 0, −0.75 -> 0x40400000 (3.0).
- read_now=1 with start=0 -> no strobes and adder_output unchanged.
- main_reset asserted with two packages in flight -> all outputs 0 on the next edge, and no strobe ever appears for the discarded packages.
